// File: rtl/tristate_bus_arbiter.sv
// Four-driver round-robin arbiter for a shared tristate bus, with registered grants and driver enables.
// Define ARB_TURNAROUND_EN to insert a one-cycle break-before-make TURN state between owners.
module tristate_bus_arbiter #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [3:0] bus_en,
  output logic [1:0] sel,
  output logic       busy,
  output logic [1:0] dbg_state,
  output logic [3:0] dbg_hcnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TURN = 2'd1,
    OWN  = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);

  state_t     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [3:0] bus_en_q, bus_en_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] own_q, own_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] hcnt_q, hcnt_d;

  logic [3:0] others;
  logic [1:0] win;
  logic       release_own;

  // First requester after p in circular order; p itself is checked last.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic [1:0] w;
    w = p;
    for (int i = 4; i >= 1; i--) begin
      idx = p + 2'(i);
      if (r[idx]) w = idx;
    end
    return w;
  endfunction

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    bus_en_d    = bus_en_q;
    sel_d       = sel_q;
    own_d       = own_q;
    ptr_d       = ptr_q;
    hcnt_d      = hcnt_q;
    others      = req & ~(4'b0001 << own_q);
    win         = 2'd0;
    release_own = 1'b0;

    case (state_q)
      IDLE: begin
        win = rr_pick(req, ptr_q);
        if (|req) begin
          gnt_d = 4'b0001 << win;
          sel_d = win;
          own_d = win;
`ifdef ARB_TURNAROUND_EN
          state_d = TURN;
`else
          state_d  = OWN;
          bus_en_d = 4'b0001 << win;
          hcnt_d   = 4'd0;
`endif
        end
      end
`ifdef ARB_TURNAROUND_EN
      TURN: begin
        // Requests arriving now wait for the next release; only the chosen winner matters.
        if (req[own_q]) begin
          state_d  = OWN;
          bus_en_d = gnt_q;
          hcnt_d   = 4'd0;
        end else begin
          state_d = IDLE;
          gnt_d   = 4'd0;
          sel_d   = 2'd0;
        end
      end
`endif
      OWN: begin
        hcnt_d      = (hcnt_q == 4'd15) ? 4'd15 : hcnt_q + 4'd1;
        release_own = !req[own_q] || ((hcnt_q == HOLD_LAST) && (|others));
        win         = rr_pick(others, own_q);
        if (release_own) begin
          ptr_d    = own_q;
          bus_en_d = 4'd0;
          if (|others) begin
            gnt_d = 4'b0001 << win;
            sel_d = win;
            own_d = win;
`ifdef ARB_TURNAROUND_EN
            state_d = TURN;
`else
            state_d  = OWN;
            bus_en_d = 4'b0001 << win;
            hcnt_d   = 4'd0;
`endif
          end else begin
            state_d = IDLE;
            gnt_d   = 4'd0;
            sel_d   = 2'd0;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        gnt_d    = 4'd0;
        bus_en_d = 4'd0;
        sel_d    = 2'd0;
      end
    endcase
  end

  // Asynchronous reset so no tristate driver stays enabled while rst is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= 4'd0;
      bus_en_q <= 4'd0;
      sel_q    <= 2'd0;
      own_q    <= 2'd0;
      ptr_q    <= 2'd3;
      hcnt_q   <= 4'd0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      bus_en_q <= bus_en_d;
      sel_q    <= sel_d;
      own_q    <= own_d;
      ptr_q    <= ptr_d;
      hcnt_q   <= hcnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign bus_en    = bus_en_q;
  assign sel       = sel_q;
  assign busy      = |bus_en_q;
  assign dbg_state = state_q;
  assign dbg_hcnt  = hcnt_q;

endmodule

// File: doc/tristate_bus_arbiter.md
TRISTATE_BUS_ARBITER -- requirements
Module: tristate_bus_arbiter

Interface
REQ-001 SHALL have parameter: HOLD_MAX, 8, maximum consecutive ownership cycles while another requester waits; legal range 1..15.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: req  input  4  request per bus driver 0..3; level-sensitive and held until done.
REQ-005 SHALL have port: gnt  output  4  registered one-hot grant or all-zero.
REQ-006 SHALL have port: bus_en  output  4  registered one-hot or all-zero tristate enables; these feed the notif1 driver enables of the shared bus.
REQ-007 SHALL have port: sel  output  2  registered binary index of current gnt bit; 0 when gnt is zero.
REQ-008 SHALL have port: busy  output  1  high when bus_en is non-zero.

Function
REQ-009 SHALL implement states IDLE, TURN, OWN; owner index ptr_own, round-robin pointer ptr, 4-bit hold counter hcnt.
REQ-010 SHALL pick winners in round-robin order ptr+1, ptr+2, ptr+3, ptr (mod 4), taking the first requester with req high.
REQ-011 IDLE: gnt=0, bus_en=0; any req high -> TURN, gnt<=winner.
REQ-012 TURN: exactly one cycle, bus_en=0, gnt held; winner req still high -> OWN, bus_en<=gnt, hcnt<=0; winner req low -> IDLE, gnt<=0, ptr unchanged.
REQ-013 OWN: bus_en=gnt; hcnt increments each cycle and saturates at 15.
REQ-014 OWN release occurs when req[owner]=0, or when hcnt==HOLD_MAX-1 and any other req is high.
REQ-015 On release: ptr<=owner; bus_en<=0 on the same edge; another eligible requester exists -> TURN with gnt<=new winner; otherwise -> IDLE, gnt<=0.
REQ-016 Owner is the sole requester: no forced release; ownership continues indefinitely.
REQ-017 bus_en SHALL never have more than one bit set, and SHALL never change directly from one non-zero value to a different non-zero value.
REQ-018 Latency: req seen at edge N -> gnt at edge N+1, bus_en at edge N+2 (from IDLE).
REQ-019 A request arriving during TURN or OWN SHALL be considered only at the next release; it SHALL never preempt the in-flight TURN.
REQ-020 sel SHALL equal the encoded gnt in every cycle; busy SHALL equal |bus_en.

Reset
REQ-021 rst high SHALL immediately force gnt=0, bus_en=0, sel=0, busy=0, state=IDLE, hcnt=0, ptr=3 (requester 0 wins first), without waiting for clk.
REQ-022 Reset asserted during OWN SHALL drop bus_en asynchronously, so no driver remains enabled.
REQ-023 After rst falls, the first edge with req high SHALL behave per REQ-011.

Configuration
REQ-024 Macro ARB_TURNAROUND_EN SHALL select the turnaround cycle.
REQ-025 Macro defined: TURN state present, giving one bus_en=0 cycle between any two owners (break-before-make) per REQ-011..015.
REQ-026 Macro undefined: TURN omitted; IDLE -> OWN sets gnt and bus_en on the same edge (latency 1); release with another eligible requester -> OWN with new owner directly, gnt and bus_en both switching on that edge; REQ-017 second clause is waived.

Verification
REQ-027 Reset, then req=0001 at edge 1 (macro on) -> gnt=0001 after edge 2, bus_en=0001 and sel=0 after edge 3.
REQ-028 req=1111 held, HOLD_MAX=8, macro on -> owners 0,1,2,3,0 in order; each bus_en burst lasts 8 cycles; exactly 1 zero cycle between bursts.
REQ-029 req=0100 only, held 40 cycles -> bus_en=0100 continuously with no forced release; hcnt saturates at 15.
REQ-030 Owner 1 active, rst pulsed mid-cycle -> bus_en=0000 before the next clk edge; after release, req=0010 is granted again via IDLE.
REQ-031 req=0001 for 1 cycle, dropped during TURN -> gnt returns to 0000; bus_en stays 0000 throughout.
REQ-032 Macro off, req=0011 -> bus_en goes 0001 (8 cycles) then 0010 with no zero cycle; latency from IDLE is 1 edge.
